// File: rtl/mem_access_unit.sv
// Load/store initiator between execute and a big-endian, word-wide data memory.
// Sub-word loads are extracted and extended; sub-word stores use read-modify-write.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; decode and latch it on accept
// LOAD  | memory read in flight; extract/extend lane into rsp_rdata
// MERGE | read word, splice store lane into write buffer
// WRITE | mem_we high for one cycle, commit write buffer
// RESP  | one-cycle response pulse, then back to IDLE
module mem_access_unit #(
    parameter int unsigned ADDR_LIMIT = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [31:0] MAX_WORD_ADDR = 32'(ADDR_LIMIT - 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        signed_q, signed_d;
    logic        err_q, err_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_err;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            2'b11:   req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        if ({req_addr[31:2], 2'b00} > MAX_WORD_ADDR) req_err = 1'b1;
    end

    // Big-endian lanes: lowest byte offset sits in the most significant bits.
    always_comb begin
        case (off_q)
            2'd0:    lane_b = mem_rdata[31:24];
            2'd1:    lane_b = mem_rdata[23:16];
            2'd2:    lane_b = mem_rdata[15:8];
            default: lane_b = mem_rdata[7:0];
        endcase
        lane_h = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

        case (size_q)
            2'b00:   load_val = {{24{signed_q & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{signed_q & lane_h[15]}}, lane_h};
            default: load_val = mem_rdata;
        endcase

        merge_val = mem_rdata;
        if (size_q == 2'b00) begin
            case (off_q)
                2'd0:    merge_val[31:24] = wdata_q[7:0];
                2'd1:    merge_val[23:16] = wdata_q[7:0];
                2'd2:    merge_val[15:8]  = wdata_q[7:0];
                default: merge_val[7:0]   = wdata_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merge_val[15:0] = wdata_q;
        end else begin
            merge_val[31:16] = wdata_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        off_d     = off_q;
        signed_d  = signed_q;
        err_d     = err_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        wbuf_d    = wbuf_q;
        rdata_d   = rdata_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    size_d   = req_size;
                    off_d    = req_addr[1:0];
                    signed_d = req_signed;
                    wdata_d  = req_wdata[15:0];
                    addr_d   = {req_addr[31:2], 2'b00};
                    if (req_err) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_size == 2'b10) begin
                        wbuf_d  = req_wdata;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_MERGE;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = load_val;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_MERGE: begin
                wbuf_d  = merge_val;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                mem_we  = 1'b1;
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            size_q   <= '0;
            off_q    <= '0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            addr_q   <= '0;
            wbuf_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            off_q    <= off_d;
            signed_q <= signed_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            wbuf_q   <= wbuf_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wbuf_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, random requests against a
// byte-level reference memory, reset-during-merge and back-to-back load sequences.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, mem_we;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] mem     [0:16383];
    logic [31:0] ref_mem [0:16383];
    assign mem_rdata = mem[mem_addr[15:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[15:2]] <= mem_wdata;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference: byte-addressed big-endian memory, expectations from plain arithmetic.
    logic        m_err, m_wr;
    logic [31:0] m_rdata, m_wdata;
    int          m_lat;

    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int nb, off, sh;
        logic [31:0] w, val, b;
        m_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                (size == 2'd2 && addr[1:0] != 2'd0) ||
                ((addr & 32'hFFFF_FFFC) > 32'(65536 - 4));
        m_rdata = '0; m_wr = 1'b0; m_wdata = '0;
        if (m_err) begin
            m_lat = 1;
            return;
        end
        nb  = 1 << size;
        off = int'(addr[1:0]);
        w   = ref_mem[addr[15:2]];
        if (!we) begin
            val = '0;
            for (int i = 0; i < nb; i++) val = (val << 8) | ((w >> (8 * (3 - off - i))) & 32'hFF);
            if (sgn && nb < 4 && val[8*nb-1]) val = val | ~((32'd1 << (8 * nb)) - 32'd1);
            m_rdata = val;
            m_lat   = 2;
        end else begin
            for (int i = 0; i < nb; i++) begin
                b  = (wdata >> (8 * (nb - 1 - i))) & 32'hFF;
                sh = 8 * (3 - off - i);
                w  = (w & ~(32'hFF << sh)) | (b << sh);
            end
            ref_mem[addr[15:2]] = w;
            m_wr    = 1'b1;
            m_wdata = w;
            m_lat   = (nb == 4) ? 2 : 3;
        end
    endtask

    int          o_lat, o_nwe, o_wecyc, o_busy_ready;
    logic        o_err;
    logic [31:0] o_rdata, o_waddr, o_wdata;

    // Issue one request from IDLE (called at a negedge) and observe until response.
    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
        chk({tag, "_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_size = 2'($urandom);
        req_signed = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
        o_lat = 0; o_nwe = 0; o_wecyc = 0; o_busy_ready = 0;
        o_err = 1'b0; o_rdata = '0; o_waddr = '0; o_wdata = '0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (req_ready) o_busy_ready++;
            if (mem_we) begin
                o_nwe++; o_wecyc = c; o_waddr = mem_addr; o_wdata = mem_wdata;
            end
            if (rsp_valid) begin
                o_lat = c; o_err = rsp_err; o_rdata = rsp_rdata;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic verify(input string tag, input logic e_err, input logic [31:0] e_rdata,
                          input int e_lat, input logic e_wr, input logic [31:0] e_waddr,
                          input logic [31:0] e_wdata);
        chk({tag, "_latency"}, 32'(o_lat), 32'(e_lat));
        chk({tag, "_err"}, 32'(o_err), 32'(e_err));
        chk({tag, "_rdata"}, o_rdata, e_rdata);
        chk({tag, "_we_pulses"}, 32'(o_nwe), e_wr ? 32'd1 : 32'd0);
        chk({tag, "_ready_busy"}, 32'(o_busy_ready), 32'd0);
        if (e_wr) begin
            chk({tag, "_we_cycle"}, 32'(o_wecyc), 32'(e_lat - 1));
            chk({tag, "_waddr"}, o_waddr, e_waddr);
            chk({tag, "_wdata"}, o_wdata, e_wdata);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_lat;
        logic        e_wr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl [15];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        r_we, r_sgn;
        logic [1:0]  r_size;
        logic [31:0] r_addr, r_wdata;
        logic [31:0] b2b_addr [3];
        logic [31:0] exp_q [$];
        int          acc_cyc [$];
        int          nacc, nrsp, extra;

        tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h100,   32'h0,        1'b0, 32'h8899AABB, 2, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h101,   32'h0,        1'b0, 32'hFFFFFF99, 2, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h103,   32'h0,        1'b0, 32'h000000BB, 2, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 2'd1, 1'b1, 32'h102,   32'h0,        1'b0, 32'hFFFFAABB, 2, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 2'd1, 1'b0, 32'h100,   32'h0,        1'b0, 32'h00008899, 2, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 2'd0, 1'b0, 32'h102,   32'h12,       1'b0, 32'h0,        3, 1'b1, 32'h889912BB};
        tbl[6]  = '{1'b0, 2'd2, 1'b0, 32'h100,   32'h0,        1'b0, 32'h889912BB, 2, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 2'd1, 1'b0, 32'h100,   32'h5555,     1'b0, 32'h0,        3, 1'b1, 32'h555512BB};
        tbl[8]  = '{1'b0, 2'd2, 1'b1, 32'h100,   32'h0,        1'b0, 32'h555512BB, 2, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 2'd1, 1'b1, 32'h101,   32'h0,        1'b1, 32'h0,        1, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h102,   32'h0,        1'b1, 32'h0,        1, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h0,     32'h0,        1'b1, 32'h0,        1, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 2'd2, 1'b0, 32'h10000, 32'h11223344, 1'b1, 32'h0,        1, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 2'd2, 1'b0, 32'hFFFC,  32'hDEADBEEF, 1'b0, 32'h0,        2, 1'b1, 32'hDEADBEEF};
        tbl[14] = '{1'b0, 2'd2, 1'b0, 32'hFFFC,  32'h0,        1'b0, 32'hDEADBEEF, 2, 1'b0, 32'h0};

        for (int i = 0; i < 16384; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[64] = 32'h8899AABB;
        ref_mem[64] = 32'h8899AABB;

        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            model(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata);
            run_req($sformatf("vec%0d", i), tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata);
            verify($sformatf("vec%0d", i), tbl[i].e_err, tbl[i].e_rdata, tbl[i].e_lat, tbl[i].e_wr,
                   {tbl[i].addr[31:2], 2'b00}, tbl[i].e_wdata);
        end

        for (int i = 0; i < 80; i++) begin
            r_we = 1'($urandom_range(0, 1));
            r_sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1, 2: r_size = 2'd0;
                3, 4, 5: r_size = 2'd1;
                6, 7, 8: r_size = 2'd2;
                default: r_size = 2'd3;
            endcase
            case ($urandom_range(0, 9))
                8:       r_addr = 32'hFFF0 + 32'($urandom_range(0, 15));
                9:       r_addr = $urandom;
                default: r_addr = 32'h100 + 32'($urandom_range(0, 63));
            endcase
            r_wdata = $urandom;
            model(r_we, r_size, r_sgn, r_addr, r_wdata);
            run_req($sformatf("rnd%0d", i), r_we, r_size, r_sgn, r_addr, r_wdata);
            verify($sformatf("rnd%0d", i), m_err, m_rdata, m_lat, m_wr, {r_addr[31:2], 2'b00}, m_wdata);
        end

        // Reset while a byte store is in MERGE: nothing written, no response.
        model(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        run_req("pre_rst_lw", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        verify("pre_rst_lw", m_err, m_rdata, m_lat, m_wr, 32'h100, m_wdata);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_merge_mem_we", 32'(mem_we), 32'd0);
        chk("rst_merge_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_merge_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_merge_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_merge_mem_addr", mem_addr, 32'd0);
        chk("rst_merge_mem_wdata", mem_wdata, 32'd0);
        chk("rst_merge_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b1;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_we || rsp_valid) extra++;
        end
        chk("rst_merge_no_activity", 32'(extra), 32'd0);
        model(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        run_req("post_rst_lw", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        verify("post_rst_lw", m_err, m_rdata, m_lat, m_wr, 32'h100, m_wdata);

        // Back-to-back loads with req_valid held high.
        b2b_addr[0] = 32'h100; b2b_addr[1] = 32'h104; b2b_addr[2] = 32'h108;
        nacc = 0; nrsp = 0;
        req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        for (int c = 0; c < 40 && nrsp < 3; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                if (exp_q.size() > 0) chk($sformatf("b2b_rsp%0d", nrsp), rsp_rdata, exp_q.pop_front());
                else chk("b2b_unexpected_rsp", 32'(rsp_valid), 32'd0);
                nrsp++;
            end
            if (req_ready) begin
                if (nacc < 3) begin
                    req_valid = 1'b1; req_addr = b2b_addr[nacc];
                    model(1'b0, 2'd2, 1'b0, b2b_addr[nacc], 32'h0);
                    exp_q.push_back(m_rdata);
                    acc_cyc.push_back(c);
                    nacc++;
                end else begin
                    req_valid = 1'b0;
                end
            end else begin
                req_addr = $urandom;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd3);
        chk("b2b_responses", 32'(nrsp), 32'd3);
        if (acc_cyc.size() == 3) begin
            chk("b2b_spacing0", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("b2b_spacing1", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
